// File: rtl/halt_dump_controller_if.sv
// Bus bundle between the end-of-program sequencer and the CPU/memory top level:
// instruction snoop, CPU hold, data-memory takeover and the dump stream.
interface halt_dump_controller_if;
    logic [31:0] inst;
    logic        inst_valid;
    logic        cpu_freeze;
    logic        mem_sel;
    logic        dm_ce;
    logic [31:0] dm_addr;
    logic [31:0] dm_rdata;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [15:0] dump_index;
    logic        dump_last;
    logic [31:0] run_cycles;
    logic        show;
    logic        stop;

    // Sequencer side
    modport master (
        input  inst, inst_valid, dm_rdata, dump_ready,
        output cpu_freeze, mem_sel, dm_ce, dm_addr,
        output dump_valid, dump_data, dump_index, dump_last,
        output run_cycles, show, stop
    );

    // Top-level / sink side
    modport slave (
        output inst, inst_valid, dm_rdata, dump_ready,
        input  cpu_freeze, mem_sel, dm_ce, dm_addr,
        input  dump_valid, dump_data, dump_index, dump_last,
        input  run_cycles, show, stop
    );
endinterface

// File: rtl/halt_dump_controller.sv
// End-of-program sequencer: detects the halt word, lets the pipeline drain,
// freezes the CPU, reads DUMP_WORDS data-memory words and streams them out.
module halt_dump_controller #(
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter int          DRAIN_CYCLES = 5,
    parameter int          DUMP_WORDS   = 512
) (
    input logic                    clk,
    input logic                    rst,
    halt_dump_controller_if.master bus
);
    typedef enum logic [2:0] {RUN, DRAIN, RD_REQ, RD_CAP, OUT, DONE} state_t;

    localparam logic [15:0] LAST_IDX   = 16'(DUMP_WORDS - 1);
    localparam logic [7:0]  DRAIN_INIT = (DRAIN_CYCLES == 0) ? 8'd0 : 8'(DRAIN_CYCLES - 1);

    state_t      state, state_nx;
    logic [7:0]  drain_cnt;
    logic [15:0] idx;
    logic [31:0] run_cnt;
    logic [31:0] dump_data_q;
    logic [15:0] dump_index_q;
    logic        dump_last_q;
    logic        show_q;
    logic        halt_hit;
    logic        hs;
    logic        frz;
    logic        ce;
    logic        vld;
    logic        stp;

    assign halt_hit = bus.inst_valid && (bus.inst == HALT_WORD);
    assign hs       = (state == OUT) && bus.dump_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nx;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nx = state;
        frz      = 1'b0;
        ce       = 1'b0;
        vld      = 1'b0;
        stp      = 1'b0;
        case (state)
            RUN: begin
                if (halt_hit) state_nx = (DRAIN_CYCLES == 0) ? RD_REQ : DRAIN;
            end
            DRAIN: begin
                if (drain_cnt == 8'd0) state_nx = RD_REQ;
            end
            RD_REQ: begin
                frz      = 1'b1;
                ce       = 1'b1;
                state_nx = RD_CAP;
            end
            RD_CAP: begin
                frz      = 1'b1;
                state_nx = OUT;
            end
            OUT: begin
                frz = 1'b1;
                vld = 1'b1;
                if (hs) state_nx = dump_last_q ? DONE : RD_REQ;
            end
            DONE: begin
                frz = 1'b1;
                stp = 1'b1;
            end
            default: state_nx = RUN;
        endcase
    end

    // Counters, read index, captured dump word and the completion pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt    <= '0;
            idx          <= '0;
            run_cnt      <= '0;
            dump_data_q  <= '0;
            dump_index_q <= '0;
            dump_last_q  <= 1'b0;
            show_q       <= 1'b0;
        end else begin
            show_q <= (state_nx == DONE) && (state != DONE);
            case (state)
                RUN: begin
                    // The halt cycle itself is counted, then the count freezes.
                    if (run_cnt != '1) run_cnt <= run_cnt + 32'd1;
                    if (halt_hit) drain_cnt <= DRAIN_INIT;
                    idx <= '0;
                end
                DRAIN: begin
                    if (drain_cnt != 8'd0) drain_cnt <= drain_cnt - 8'd1;
                    idx <= '0;
                end
                RD_CAP: begin
                    // Memory returns data one cycle after the RD_REQ enable.
                    dump_data_q  <= bus.dm_rdata;
                    dump_index_q <= idx;
                    dump_last_q  <= (idx == LAST_IDX);
                end
                OUT: begin
                    if (hs && !dump_last_q) idx <= idx + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.cpu_freeze = frz;
    assign bus.mem_sel    = frz;
    assign bus.dm_ce      = ce;
    assign bus.dm_addr    = {14'd0, idx, 2'b00};
    assign bus.dump_valid = vld;
    assign bus.dump_data  = dump_data_q;
    assign bus.dump_index = dump_index_q;
    assign bus.dump_last  = dump_last_q;
    assign bus.run_cycles = run_cnt;
    assign bus.show       = show_q;
    assign bus.stop       = stp;
endmodule

// File: tb/tb_halt_dump_controller.sv
// Bench for halt_dump_controller: instance a (drain 5, 4 words) and instance b
// (drain 0, 512 words). A timestamp model predicts every output each cycle.
module tb_halt_dump_controller;
    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    halt_dump_controller_if ifa ();
    halt_dump_controller_if ifb ();

    halt_dump_controller #(.HALT_WORD(HALT), .DRAIN_CYCLES(5), .DUMP_WORDS(4)) dut_a (
        .clk(clk), .rst(rst_a), .bus(ifa)
    );
    halt_dump_controller #(.HALT_WORD(HALT), .DRAIN_CYCLES(0), .DUMP_WORDS(512)) dut_b (
        .clk(clk), .rst(rst_b), .bus(ifb)
    );

    // Data memory contents and one-cycle read latency per instance
    logic [31:0] mem [0:511];
    initial begin
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        for (int i = 4; i < 512; i++) mem[i] = 32'hA500_0000 + 32'(i);
    end
    always @(posedge clk) begin
        if (ifa.dm_ce) ifa.dm_rdata <= mem[ifa.dm_addr[10:2]];
        if (ifb.dm_ce) ifb.dm_rdata <= mem[ifb.dm_addr[10:2]];
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    typedef struct {int cyc; logic [31:0] data; logic [15:0] idx; logic last;} hs_t;
    typedef struct {int cyc; logic [31:0] addr;} ce_t;
    hs_t hs_a[$], hs_b[$];
    ce_t ce_a[$], ce_b[$];

    // Model: halt time fixes the freeze time; each word is requested at req_c,
    // presented from req_c+2 until accepted, next request the cycle after.
    int D [2] = '{5, 0};
    int N [2] = '{4, 512};
    bit halted [2], done [2], prev_frz [2];
    int cyc [2], halt_c [2], req0 [2], req_c [2], widx [2], done_c [2];
    int frz_rise [2], show_cnt [2];

    task automatic model_step(input int k, input logic r, input logic frz, input logic msel,
                              input logic ce, input logic [31:0] addr, input logic vld,
                              input logic [31:0] data, input logic [15:0] index, input logic last,
                              input logic [31:0] runc, input logic show, input logic stop,
                              input logic iv, input logic [31:0] ins, input logic rdy);
        string p;
        int c;
        logic e_frz, e_ce, e_vld, e_show, e_stop;
        logic [31:0] e_run;
        hs_t h;
        ce_t q;
        p = (k == 0) ? "a." : "b.";
        if (r) begin
            chk({p, "rst_freeze"}, frz, 0);   chk({p, "rst_mem_sel"}, msel, 0);
            chk({p, "rst_dm_ce"}, ce, 0);     chk({p, "rst_dm_addr"}, addr, 0);
            chk({p, "rst_valid"}, vld, 0);    chk({p, "rst_data"}, data, 0);
            chk({p, "rst_index"}, index, 0);  chk({p, "rst_last"}, last, 0);
            chk({p, "rst_run"}, runc, 0);     chk({p, "rst_show"}, show, 0);
            chk({p, "rst_stop"}, stop, 0);
            halted[k] = 0; done[k] = 0; cyc[k] = 0; prev_frz[k] = 0;
            return;
        end
        c      = cyc[k];
        e_run  = (!halted[k] || c <= halt_c[k]) ? 32'(c) : 32'(halt_c[k] + 1);
        e_frz  = halted[k] && c >= req0[k];
        e_ce   = halted[k] && !done[k] && c == req_c[k];
        e_vld  = halted[k] && !done[k] && c >= req_c[k] + 2;
        e_show = done[k] && c == done_c[k];
        e_stop = done[k];
        chk({p, "run_cycles"}, runc, e_run);
        chk({p, "cpu_freeze"}, frz, e_frz);
        chk({p, "mem_sel"}, msel, e_frz);
        chk({p, "dm_ce"}, ce, e_ce);
        chk({p, "dump_valid"}, vld, e_vld);
        chk({p, "show"}, show, e_show);
        chk({p, "stop"}, stop, e_stop);
        if (e_ce) chk({p, "dm_addr"}, addr, 32'(widx[k] * 4));
        if (e_vld) begin
            chk({p, "dump_data"}, data, mem[widx[k]]);
            chk({p, "dump_index"}, index, 32'(widx[k]));
            chk({p, "dump_last"}, last, (widx[k] == N[k] - 1));
        end
        // observations for the literal checks
        if (frz && !prev_frz[k]) frz_rise[k] = c;
        prev_frz[k] = frz;
        if (show) show_cnt[k]++;
        if (vld && rdy) begin
            h = '{c, data, index, last};
            if (k == 0) hs_a.push_back(h); else hs_b.push_back(h);
        end
        if (ce) begin
            q = '{c, addr};
            if (k == 0) ce_a.push_back(q); else ce_b.push_back(q);
        end
        // advance the model with this cycle's inputs
        if (!halted[k] && iv && ins == HALT) begin
            halted[k] = 1; halt_c[k] = c; req0[k] = c + 1 + D[k];
            req_c[k] = req0[k]; widx[k] = 0;
        end else if (e_vld && rdy) begin
            if (widx[k] == N[k] - 1) begin
                done[k] = 1; done_c[k] = c + 1;
            end else begin
                widx[k]++; req_c[k] = c + 1;
            end
        end
        cyc[k] = c + 1;
    endtask

    // Single compare process, mid-cycle
    always @(negedge clk) begin
        model_step(0, rst_a, ifa.cpu_freeze, ifa.mem_sel, ifa.dm_ce, ifa.dm_addr, ifa.dump_valid,
                   ifa.dump_data, ifa.dump_index, ifa.dump_last, ifa.run_cycles, ifa.show,
                   ifa.stop, ifa.inst_valid, ifa.inst, ifa.dump_ready);
        model_step(1, rst_b, ifb.cpu_freeze, ifb.mem_sel, ifb.dm_ce, ifb.dm_addr, ifb.dump_valid,
                   ifb.dump_data, ifb.dump_index, ifb.dump_last, ifb.run_cycles, ifb.show,
                   ifb.stop, ifb.inst_valid, ifb.inst, ifb.dump_ready);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd();
        return {1'b0, 31'($urandom)};
    endfunction

    int hs_cyc_exp [4] = '{18, 21, 31, 34};
    int ce_cyc_exp [4] = '{16, 19, 22, 32};
    logic [31:0] data_exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    initial begin
        int bad, lasts, n;
        ifa.inst = '0; ifa.inst_valid = 1'b0; ifa.dump_ready = 1'b0; ifa.dm_rdata = '0;
        ifb.inst = '0; ifb.inst_valid = 1'b0; ifb.dump_ready = 1'b0; ifb.dm_rdata = '0;
        repeat (3) tick();

        // Basic run with an invalid halt, extra halts, backpressure on word 2
        rst_a = 1'b0;
        for (int c = 0; c <= 45; c++) begin
            ifa.inst_valid = (c != 4);
            ifa.inst       = (c == 4 || c == 10 || c == 12 || c == 26) ? HALT : rnd();
            ifa.dump_ready = (c >= 40) ? c[0] : !(c >= 24 && c <= 30);
            tick();
            if (c == 10) chk("a.run_cycles_literal", ifa.run_cycles, 32'd11);
        end
        chk("a.freeze_rise_cycle", 32'(frz_rise[0]), 32'd16);
        chk("a.handshake_count", 32'(hs_a.size()), 32'd4);
        chk("a.ce_count", 32'(ce_a.size()), 32'd4);
        if (hs_a.size() == 4 && ce_a.size() == 4)
            for (int i = 0; i < 4; i++) begin
                chk("a.hs_data_literal", hs_a[i].data, data_exp[i]);
                chk("a.hs_index_literal", 32'(hs_a[i].idx), 32'(i));
                chk("a.hs_last_literal", 32'(hs_a[i].last), 32'(i == 3));
                chk("a.hs_cycle_literal", 32'(hs_a[i].cyc), 32'(hs_cyc_exp[i]));
                chk("a.ce_cycle_literal", 32'(ce_a[i].cyc), 32'(ce_cyc_exp[i]));
            end
        chk("a.show_pulses", 32'(show_cnt[0]), 32'd1);
        chk("a.stop_sticky", ifa.stop, 1);
        chk("a.dm_ce_after_done", ifa.dm_ce, 0);

        // Reset while word 1 is held in OUT
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        for (int c = 0; c <= 13; c++) begin
            ifa.inst_valid = 1'b1;
            ifa.inst       = (c == 2) ? HALT : rnd();
            ifa.dump_ready = (c != 13);
            tick();
        end
        chk("a.hold_valid", ifa.dump_valid, 1);
        chk("a.hold_index", 32'(ifa.dump_index), 32'd1);
        chk("a.hold_data", ifa.dump_data, 32'h22);
        rst_a = 1'b1;
        #1;
        chk("a.async_rst_valid", ifa.dump_valid, 0);
        chk("a.async_rst_index", 32'(ifa.dump_index), 32'd0);
        chk("a.async_rst_freeze", ifa.cpu_freeze, 0);
        hs_a.delete(); ce_a.delete();
        tick();
        rst_a = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            ifa.inst_valid = 1'b1;
            ifa.inst       = (c == 0) ? HALT : rnd();
            ifa.dump_ready = 1'b1;
            tick();
        end
        chk("a.restart_run_cycles", ifa.run_cycles, 32'd1);
        chk("a.restart_hs_count", 32'(hs_a.size()), 32'd1);
        chk("a.restart_ce_count", 32'(ce_a.size()), 32'd2);
        if (hs_a.size() >= 1 && ce_a.size() >= 1) begin
            chk("a.restart_first_ce_cycle", 32'(ce_a[0].cyc), 32'd6);
            chk("a.restart_first_addr", ce_a[0].addr, 32'd0);
            chk("a.restart_first_index", 32'(hs_a[0].idx), 32'd0);
            chk("a.restart_first_data", hs_a[0].data, 32'h11);
            chk("a.restart_first_hs_cycle", 32'(hs_a[0].cyc), 32'd8);
        end
        rst_a = 1'b1;

        // Zero drain and full-depth dump
        rst_b = 1'b0;
        for (int c = 0; c <= 3; c++) begin
            ifb.inst       = HALT;
            ifb.inst_valid = (c == 3);
            ifb.dump_ready = 1'b1;
            tick();
        end
        chk("b.zero_drain_ce", ifb.dm_ce, 1);
        chk("b.zero_drain_addr", ifb.dm_addr, 32'd0);
        chk("b.zero_drain_run", ifb.run_cycles, 32'd4);
        n = 0;
        while (!ifb.stop && n < 2000) begin
            ifb.inst_valid = 1'b1;
            ifb.inst       = n[3] ? HALT : rnd();
            tick();
            n++;
        end
        chk("b.done_within_budget", ifb.stop, 1);
        chk("b.handshake_count", 32'(hs_b.size()), 32'd512);
        chk("b.ce_count", 32'(ce_b.size()), 32'd512);
        if (hs_b.size() == 512 && ce_b.size() == 512) begin
            bad = 0; lasts = 0;
            for (int i = 0; i < 512; i++) begin
                if (ce_b[i].addr != 32'(i * 4) || hs_b[i].idx != 16'(i)) bad++;
                if (hs_b[i].last) lasts++;
            end
            chk("b.addr_index_steps_bad", 32'(bad), 32'd0);
            chk("b.last_count", 32'(lasts), 32'd1);
            chk("b.last_at_511", 32'(hs_b[511].last), 32'd1);
            chk("b.final_addr", ce_b[511].addr, 32'd2044);
            chk("b.total_cycles", 32'(hs_b[511].cyc - ce_b[0].cyc + 1), 32'd1536);
        end
        tick();
        chk("b.show_pulses", 32'(show_cnt[1]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
